// File: rtl/fifo_pkg.sv
// Shared helpers for the FIFO slice: constant functions used to size
// pointers and occupancy counters from the depth parameter.
package fifo_pkg;

  function automatic int clog2(input int value);
    int result;
    int remaining;
    result = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sync_fifo_core.sv
// Register-array FIFO with first-word-fall-through read. The write port never
// stalls; a write that finds the array full with no pop drops the data and
// latches a sticky overflow flag.
module sync_fifo_core
  import fifo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int CNT_W = clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_wr_valid,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_ready,
  output logic             o_rd_valid,
  output logic [WIDTH-1:0] o_rd_data,
  output logic [CNT_W-1:0] o_level,
  output logic             o_overflow
);

  localparam int ADDR_W = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [ADDR_W-1:0] r_rdPtr;
  logic [ADDR_W-1:0] r_wrPtr;
  logic [CNT_W-1:0]  r_level;
  logic              r_overflow;

  logic w_full;
  logic w_pop;
  logic w_write;

  // Explicit wrap keeps the pointers inside the array for any DEPTH.
  function automatic logic [ADDR_W-1:0] nextPtr(input logic [ADDR_W-1:0] ptr);
    return (ptr == ADDR_W'(DEPTH - 1)) ? '0 : ptr + ADDR_W'(1);
  endfunction

  assign w_full  = (r_level == CNT_W'(DEPTH));
  assign w_pop   = (r_level != '0) && i_rd_ready;
  assign w_write = i_wr_valid && (!w_full || w_pop);

  always_ff @(posedge clock) begin
    if (w_write) begin
      r_mem[r_wrPtr] <= i_wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rdPtr    <= '0;
      r_wrPtr    <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_write) begin
        r_wrPtr <= nextPtr(r_wrPtr);
      end
      if (w_pop) begin
        r_rdPtr <= nextPtr(r_rdPtr);
      end
      if (w_write && !w_pop) begin
        r_level <= r_level + CNT_W'(1);
      end else if (!w_write && w_pop) begin
        r_level <= r_level - CNT_W'(1);
      end
      // A pop in the same cycle makes room, so only a full, non-popping write is an error.
      if (i_wr_valid && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign o_rd_valid = (r_level != '0);
  assign o_rd_data  = r_mem[r_rdPtr];
  assign o_level    = r_level;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/latency_fifo.sv
// Credit-based elastic output stage for a fixed-latency, non-stallable pipeline:
// an issue is allowed only while a FIFO slot is reserved for its future result.
module latency_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 1,
  parameter int DEPTH   = 4,
  localparam int CNT_W  = clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [CNT_W-1:0] level,
  output logic             overflow
);

  if (DEPTH < 1) begin : g_badDepth
    $error("latency_fifo: DEPTH must be at least 1");
  end

  if (LATENCY < 0) begin : g_badLatency
    $error("latency_fifo: LATENCY must not be negative");
  end

  logic [CNT_W-1:0] r_reserved;
  logic             w_issueFire;
  logic             w_popFire;

  // Credits depend only on the registered count, so a pop frees its slot one cycle later.
  assign issue_ready = (r_reserved < CNT_W'(DEPTH));
  assign w_issueFire = issue_valid && issue_ready;
  assign w_popFire   = m_valid && m_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_reserved <= '0;
    end else begin
      case ({w_issueFire, w_popFire})
        2'b10:   r_reserved <= r_reserved + CNT_W'(1);
        2'b01:   r_reserved <= r_reserved - CNT_W'(1);
        default: r_reserved <= r_reserved;
      endcase
    end
  end

  sync_fifo_core #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_core (
    .clock      (clock),
    .reset      (reset),
    .i_wr_valid (in_valid),
    .i_wr_data  (in_data),
    .i_rd_ready (m_ready),
    .o_rd_valid (m_valid),
    .o_rd_data  (m_data),
    .o_level    (level),
    .o_overflow (overflow)
  );

endmodule

// File: tb/tb_latency_fifo.sv
// Directed bench for latency_fifo with a two-stage pipeline model between
// issue fire and in_valid; inputs change on the falling edge, outputs are sampled there.
module tb_latency_fifo;

  localparam int WIDTH   = 16;
  localparam int LATENCY = 2;
  localparam int DEPTH   = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic             issue_valid;
  logic [WIDTH-1:0] issue_data;
  logic             issue_ready;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic [2:0]       level;
  logic             overflow;

  logic             forceValid;
  logic [WIDTH-1:0] forceData;
  logic [LATENCY-1:0] pipeValid;
  logic [WIDTH-1:0]   pipeData [LATENCY];

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  // Upstream pipeline model: delays {issue fire, data} by LATENCY cycles, shares reset.
  always @(posedge clock) begin
    if (reset) begin
      pipeValid <= '0;
    end else begin
      pipeValid[0] <= issue_valid && issue_ready;
      pipeData[0]  <= issue_data;
      for (int i = 1; i < LATENCY; i++) begin
        pipeValid[i] <= pipeValid[i-1];
        pipeData[i]  <= pipeData[i-1];
      end
    end
  end

  assign in_valid = pipeValid[LATENCY-1] || forceValid;
  assign in_data  = forceValid ? forceData : pipeData[LATENCY-1];

  latency_fifo #(
    .WIDTH(WIDTH),
    .LATENCY(LATENCY),
    .DEPTH(DEPTH)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .level       (level),
    .overflow    (overflow)
  );

  task automatic test_reset;
    reset = 1'b1; issue_valid = 1'b0; issue_data = '0; m_ready = 1'b0;
    forceValid = 1'b0; forceData = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++; if (m_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_m_valid got=%0b want=0", m_valid); end
    checks++; if (level !== 3'd0) begin failures++; $display("[TB] FAIL reset_level got=%0d want=0", level); end
    checks++; if (issue_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_issue_ready got=%0b want=1", issue_ready); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL reset_overflow got=%0b want=0", overflow); end
  endtask

  task automatic test_stream;
    int firstValid = -1;
    int popped = 0;
    logic readyDropped = 1'b0;
    m_ready = 1'b1;
    for (int k = 0; k < 22; k++) begin
      @(negedge clock);
      if (m_valid === 1'b1) begin
        if (firstValid < 0) firstValid = k;
        checks++;
        if (m_data !== WIDTH'(popped + 1)) begin
          failures++; $display("[TB] FAIL stream_data idx=%0d got=%h want=%h", popped, m_data, WIDTH'(popped + 1));
        end
        popped++;
      end
      if (issue_ready !== 1'b1) readyDropped = 1'b1;
      issue_valid = (k < 16);
      issue_data  = WIDTH'(k + 1);
    end
    issue_valid = 1'b0;
    checks++; if (firstValid != 3) begin failures++; $display("[TB] FAIL stream_first_latency got=%0d want=3", firstValid); end
    checks++; if (popped != 16) begin failures++; $display("[TB] FAIL stream_count got=%0d want=16", popped); end
    checks++; if (readyDropped !== 1'b0) begin failures++; $display("[TB] FAIL stream_issue_ready_dropped got=%0b want=0", readyDropped); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL stream_overflow got=%0b want=0", overflow); end
  endtask

  task automatic test_fill;
    m_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      checks++;
      if (issue_ready !== (k < 4)) begin
        failures++; $display("[TB] FAIL fill_issue_ready cycle=%0d got=%0b want=%0b", k, issue_ready, (k < 4));
      end
      issue_valid = 1'b1;
      issue_data  = WIDTH'(16'h0100 + k);
    end
    issue_valid = 1'b0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clock);
      if (j < 4) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== WIDTH'(16'h0100 + j)) begin
          failures++; $display("[TB] FAIL fill_drain_data idx=%0d got=%b/%h want=1/%h", j, m_valid, m_data, WIDTH'(16'h0100 + j));
        end
      end else begin
        checks++; if (m_valid !== 1'b0) begin failures++; $display("[TB] FAIL fill_drain_empty got=%0b want=0", m_valid); end
      end
      if (j == 0) begin
        checks++; if (level !== 3'd4) begin failures++; $display("[TB] FAIL fill_level got=%0d want=4", level); end
        checks++; if (issue_ready !== 1'b0) begin failures++; $display("[TB] FAIL fill_full_ready got=%0b want=0", issue_ready); end
      end
      if (j == 1) begin
        checks++; if (issue_ready !== 1'b1) begin failures++; $display("[TB] FAIL fill_credit_return got=%0b want=1", issue_ready); end
      end
      m_ready = 1'b1;
    end
    m_ready = 1'b0;
  endtask

  task automatic test_credit_race;
    m_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      checks++; if (issue_ready !== 1'b1) begin failures++; $display("[TB] FAIL race_fill_ready cycle=%0d got=%0b want=1", k, issue_ready); end
      issue_valid = 1'b1;
      issue_data  = WIDTH'(16'h0200 + k);
    end
    @(negedge clock);
    issue_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    checks++; if (level !== 3'd4) begin failures++; $display("[TB] FAIL race_level_full got=%0d want=4", level); end
    checks++; if (issue_ready !== 1'b0) begin failures++; $display("[TB] FAIL race_ready_full got=%0b want=0", issue_ready); end
    checks++; if (m_data !== 16'h0200) begin failures++; $display("[TB] FAIL race_head got=%h want=0200", m_data); end
    m_ready = 1'b1; issue_valid = 1'b1; issue_data = 16'h02FF;
    @(negedge clock);
    checks++; if (issue_ready !== 1'b1) begin failures++; $display("[TB] FAIL race_ready_after_pop got=%0b want=1", issue_ready); end
    checks++; if (level !== 3'd3) begin failures++; $display("[TB] FAIL race_level_after_pop got=%0d want=3", level); end
    checks++; if (m_data !== 16'h0201) begin failures++; $display("[TB] FAIL race_head_after_pop got=%h want=0201", m_data); end
    m_ready = 1'b0; issue_valid = 1'b1; issue_data = 16'h0204;
    @(negedge clock);
    checks++; if (issue_ready !== 1'b0) begin failures++; $display("[TB] FAIL race_ready_refill got=%0b want=0", issue_ready); end
    checks++; if (level !== 3'd3) begin failures++; $display("[TB] FAIL race_level_inflight got=%0d want=3", level); end
    issue_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    checks++; if (level !== 3'd4) begin failures++; $display("[TB] FAIL race_level_refill got=%0d want=4", level); end
    checks++; if (m_data !== 16'h0201) begin failures++; $display("[TB] FAIL race_head_refill got=%h want=0201", m_data); end
  endtask

  task automatic test_overflow;
    logic [WIDTH-1:0] expData [4];
    expData[0] = 16'h0202; expData[1] = 16'h0203; expData[2] = 16'h0204; expData[3] = 16'hDEAD;
    @(negedge clock);
    checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL ovf_initial got=%0b want=0", overflow); end
    m_ready = 1'b1; forceValid = 1'b1; forceData = 16'hDEAD;
    @(negedge clock);
    checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL ovf_legal_write got=%0b want=0", overflow); end
    checks++; if (level !== 3'd4) begin failures++; $display("[TB] FAIL ovf_legal_level got=%0d want=4", level); end
    checks++; if (m_data !== 16'h0202) begin failures++; $display("[TB] FAIL ovf_legal_head got=%h want=0202", m_data); end
    m_ready = 1'b0; forceValid = 1'b1; forceData = 16'hBEEF;
    @(negedge clock);
    checks++; if (overflow !== 1'b1) begin failures++; $display("[TB] FAIL ovf_set got=%0b want=1", overflow); end
    checks++; if (level !== 3'd4) begin failures++; $display("[TB] FAIL ovf_level got=%0d want=4", level); end
    checks++; if (m_data !== 16'h0202) begin failures++; $display("[TB] FAIL ovf_head got=%h want=0202", m_data); end
    forceValid = 1'b0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clock);
      if (j == 0) begin
        checks++; if (overflow !== 1'b1) begin failures++; $display("[TB] FAIL ovf_sticky got=%0b want=1", overflow); end
      end
      if (j < 4) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== expData[j]) begin
          failures++; $display("[TB] FAIL ovf_drain idx=%0d got=%b/%h want=1/%h", j, m_valid, m_data, expData[j]);
        end
      end else begin
        checks++; if (m_valid !== 1'b0) begin failures++; $display("[TB] FAIL ovf_drain_empty got=%0b want=0", m_valid); end
      end
      m_ready = 1'b1;
    end
    m_ready = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL ovf_cleared_by_reset got=%0b want=0", overflow); end
    checks++; if (issue_ready !== 1'b1) begin failures++; $display("[TB] FAIL ovf_reset_ready got=%0b want=1", issue_ready); end
    reset = 1'b0;
  endtask

  task automatic test_mid_reset;
    @(negedge clock);
    m_ready = 1'b0; forceValid = 1'b1; forceData = 16'h0F00;
    issue_valid = 1'b1; issue_data = 16'h0300;
    for (int k = 1; k < 4; k++) begin
      @(negedge clock);
      forceValid = 1'b0;
      issue_data = WIDTH'(16'h0300 + k);
    end
    @(negedge clock);
    checks++; if (level !== 3'd3) begin failures++; $display("[TB] FAIL midrst_setup_level got=%0d want=3", level); end
    checks++; if (issue_ready !== 1'b0) begin failures++; $display("[TB] FAIL midrst_setup_ready got=%0b want=0", issue_ready); end
    checks++; if (m_data !== 16'h0F00) begin failures++; $display("[TB] FAIL midrst_setup_head got=%h want=0F00", m_data); end
    issue_valid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    checks++; if (level !== 3'd0) begin failures++; $display("[TB] FAIL midrst_level got=%0d want=0", level); end
    checks++; if (m_valid !== 1'b0) begin failures++; $display("[TB] FAIL midrst_m_valid got=%0b want=0", m_valid); end
    checks++; if (issue_ready !== 1'b1) begin failures++; $display("[TB] FAIL midrst_issue_ready got=%0b want=1", issue_ready); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL midrst_overflow got=%0b want=0", overflow); end
    reset = 1'b0;
    m_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      checks++;
      if (m_valid !== 1'b0 || level !== 3'd0) begin
        failures++; $display("[TB] FAIL midrst_stale cycle=%0d got=%b/%0d want=0/0", k, m_valid, level);
      end
    end
    m_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_stream();
    test_fill();
    test_credit_race();
    test_overflow();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/latency_fifo.md
Name: latency_fifo

Overview:
Elastic output stage placed directly downstream of a fixed-latency, non-stallable pipeline built from `delay` stages. It converts the pipeline's free-running output (valid, data) into a valid/ready stream. It uses credits: the upstream issuer may launch a transaction into the pipeline only when buffer space is reserved for its eventual result. This guarantees that no result is lost when the consumer stalls.

Parameters:
- WIDTH, 32, data width of the pipeline result.
- LATENCY, 1, cycles from issue to result arrival on in_valid. Must equal the sum of the upstream `delay` DELAY values.
- DEPTH, 4, FIFO entries. Must be >= 1. DEPTH >= LATENCY+2 is required for sustained 1 issue/cycle.

Ports:
- clock, input, 1, rising-edge clock.
- reset, input, 1, synchronous, active-high reset.
- issue_valid, input, 1, upstream wants to launch one transaction into the pipeline.
- issue_ready, output, 1, credit available. An issue fires when issue_valid && issue_ready.
- in_valid, input, 1, pipeline result present this cycle. It is the delayed issue fire.
- in_data, input, WIDTH, pipeline result.
- m_valid, output, 1, output word available.
- m_ready, input, 1, consumer accepts the word. A pop fires when m_valid && m_ready.
- m_data, output, WIDTH, head of FIFO. Only meaningful while m_valid=1.
- level, output, clog2(DEPTH+1), number of stored entries.
- overflow, output, 1, sticky protocol-error flag.

Behaviour:
Reset values:
- rd_ptr=0, wr_ptr=0, level=0, reserved=0.
- m_valid=0, issue_ready=1, overflow=0.
- m_data is don't-care.

Credit counter (`reserved`):
- `reserved` counts stored entries plus in-flight transactions. Range 0..DEPTH.
- issue_ready = (reserved < DEPTH). It is combinational from the registered count only, with no dependence on m_ready or issue_valid.
- Issue fire only: reserved+1. Pop fire only: reserved-1. Both in the same cycle: unchanged.

Storage:
- Register array of DEPTH entries with first-word-fall-through read: m_data = mem[rd_ptr]; m_valid = (level != 0).
- in_valid=1 and level<DEPTH: write mem[wr_ptr] and advance wr_ptr.
- Pop: advance rd_ptr.
- Pointers wrap from DEPTH-1 to 0. This holds for non-power-of-2 DEPTH.
- Simultaneous write and pop: level unchanged, both pointers advance.

Timing:
- No write-to-output bypass. Data written at cycle t is visible on m_valid/m_data at t+1, even when level was 0.
- Issue at t: in_valid at t+LATENCY, m_valid at t+LATENCY+1.
- Pop at c frees its credit at c+1. The full credit loop is LATENCY+2 cycles.

Overflow:
- in_valid=1 while level==DEPTH and no pop in that cycle: write dropped, storage and level unchanged, overflow set to 1.
- overflow is cleared only by reset.
- in_valid=1 with level==DEPTH but a pop in the same cycle is a legal write, not an overflow.

Reset mid-operation:
- All state clears on the next edge.
- The upstream `delay` stages share reset, so in-flight results are discarded and the credits stay consistent.

Decomposition:
- Package fifo_pkg holds the clog2 constant function. ADDR_W=clog2(DEPTH) with minimum 1, and CNT_W=clog2(DEPTH+1), are derived locally.
- One sub-module, sync_fifo_core (WIDTH, DEPTH), provides storage, pointers, level, FWFT read and overflow detect.
- The top level, latency_fifo, adds the credit counter, issue_ready and parameter checks.

Test Plan (WIDTH=16, LATENCY=2, DEPTH=4; the bench models the pipeline with a delay of 2 on {issue fire, data}):
1. Hold reset 3 cycles, then release → m_valid=0, level=0, issue_ready=1, overflow=0 on the first cycle after release.
2. m_ready=1, issue every cycle with data 0x0001..0x0010 → outputs appear in order, first m_valid 3 cycles after the first issue, issue_ready never drops, overflow=0.
3. m_ready=0, issue_valid=1 continuously → exactly 4 issues accepted, then issue_ready=0; level reaches 4. Then raise m_ready → the 4 words pop in order, and issue_ready=1 the cycle after the first pop.
4. reserved=4 with pop and issue_valid in the same cycle → no issue that cycle; reserved=3 and issue_ready=1 the next cycle.
5. level=4, m_ready=0, force in_valid=1 with data 0xDEAD → overflow=1 (sticky), level=4, head word unchanged. Repeat with m_ready=1 → no overflow; 0xDEAD stored at the tail.
6. Assert reset with level=3 and 2 results in flight → next cycle level=0, m_valid=0, issue_ready=1, overflow=0; no stale results emerge afterward.
